// File: rtl/stone_drawer.sv
// Frame-triggered sprite renderer: walks the stone RAM records and streams one
// SPRITE_SIZE x SPRITE_SIZE sprite per visible record to the VGA pixel writer.
module stone_drawer #(
    parameter int SPRITE_SIZE  = 16,
    parameter int READ_LATENCY = 2,
    parameter int SCREEN_W     = 320,
    parameter int SCREEN_H     = 240
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [3:0]  quantity,
    input  logic [31:0] data,
    output logic        draw_stone_flag,
    output logic [3:0]  draw_index,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        done
);

    localparam int CW = $clog2(SPRITE_SIZE);
    localparam int WW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
    localparam logic [CW-1:0] EDGE_POS = CW'(SPRITE_SIZE - 1);
    localparam logic [WW-1:0] WAIT_END = WW'(READ_LATENCY - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WAIT, S_LATCH, S_DRAW, S_NEXT, S_DONE
    } state_t;

    typedef struct packed {
        logic [8:0] px;
        logic [7:0] py;
        logic [1:0] kind;
        logic       vis;
    } rec_t;

    state_t          state, nxt_state;
    rec_t            rec, src;
    logic [CW-1:0]   col, row, nxt_col, nxt_row;
    logic [WW-1:0]   wait_cnt;
    logic [9:0]      sx, sy;
    logic            in_bounds, border, last_px;
    logic [2:0]      pix_colour;
    logic            unused_bits;

    assign unused_bits = ^{data[22:19], data[10:4], data[0]};

    // In S_LATCH the record is not yet registered, so decode straight from RAM q.
    assign src     = (state == S_LATCH) ? rec_t'({data[31:23], data[18:11], data[3:2], data[1]}) : rec;
    assign last_px = (col == EDGE_POS) && (row == EDGE_POS);

    always_comb begin
        nxt_state = state;
        nxt_col   = '0;
        nxt_row   = '0;
        case (state)
            S_IDLE:  if (start) nxt_state = S_ADDR;
            S_ADDR:  nxt_state = (draw_index >= quantity) ? S_DONE : S_WAIT;
            S_WAIT:  if (wait_cnt == WAIT_END) nxt_state = S_LATCH;
            S_LATCH: nxt_state = src.vis ? S_DRAW : S_NEXT;
            S_DRAW: begin
                if (last_px) begin
                    nxt_state = S_NEXT;
                end else begin
                    nxt_col = col + CW'(1);
                    nxt_row = (col == EDGE_POS) ? row + CW'(1) : row;
                end
            end
            S_NEXT:  nxt_state = S_ADDR;
            S_DONE:  nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    // Pixel outputs are computed for the pixel about to be shown, so the
    // registered plot lines up exactly with the cycles spent in S_DRAW.
    always_comb begin
        sx         = {1'b0, src.px} + 10'(nxt_col);
        sy         = {2'b0, src.py} + 10'(nxt_row);
        in_bounds  = (sx < 10'(SCREEN_W)) && (sy < 10'(SCREEN_H));
        border     = (nxt_col == '0) || (nxt_col == EDGE_POS) ||
                     (nxt_row == '0) || (nxt_row == EDGE_POS);
        pix_colour = 3'b000;
        if (!border) begin
            case (src.kind)
                2'b00:   pix_colour = 3'b111;
                2'b01:   pix_colour = 3'b110;
                2'b10:   pix_colour = 3'b011;
                default: pix_colour = 3'b101;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) state <= S_IDLE;
        else         state <= nxt_state;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            draw_stone_flag <= 1'b0;
            draw_index      <= '0;
            x               <= '0;
            y               <= '0;
            colour          <= '0;
            plot            <= 1'b0;
            done            <= 1'b0;
            col             <= '0;
            row             <= '0;
            wait_cnt        <= '0;
            rec             <= '0;
        end else begin
            done <= (state == S_DONE);
            if (state == S_IDLE && start) draw_stone_flag <= 1'b1;
            else if (state == S_DONE)     draw_stone_flag <= 1'b0;

            if (state == S_NEXT)      draw_index <= draw_index + 4'd1;
            else if (state == S_DONE) draw_index <= '0;

            wait_cnt <= (state == S_WAIT) ? wait_cnt + WW'(1) : '0;
            if (state == S_LATCH) rec <= src;

            col  <= nxt_col;
            row  <= nxt_row;
            plot <= (nxt_state == S_DRAW) && in_bounds;
            if (nxt_state == S_DRAW) begin
                x      <= sx[8:0];
                y      <= sy[7:0];
                colour <= pix_colour;
            end
        end
    end

endmodule

// File: tb/tb_stone_drawer.sv
// Randomized self-checking bench for stone_drawer against a pixel-list model.
module tb_stone_drawer;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  quantity = 4'd0;
    logic [31:0] data = '0;
    logic        draw_stone_flag;
    logic [3:0]  draw_index;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        done;

    stone_drawer dut (
        .clock(clock), .resetn(resetn), .start(start), .quantity(quantity), .data(data),
        .draw_stone_flag(draw_stone_flag), .draw_index(draw_index), .x(x), .y(y),
        .colour(colour), .plot(plot), .done(done)
    );

    always #5 clock = ~clock;

    // Two-cycle read-latency RAM
    logic [31:0] mem [16];
    logic [31:0] q1 = '0;
    always @(posedge clock) begin
        q1   <= mem[draw_index];
        data <= q1;
    end

    int errors = 0;
    int checks = 0;

    // Monitor: owns all observation state; tasks only read it.
    int          cyc = 0;
    int          flag_cycles = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          done_with_flag = 0;
    int          plots_idx [16];
    logic [19:0] got [$];
    always @(negedge clock) begin
        cyc++;
        if (plot) begin
            got.push_back({x, y, colour});
            plots_idx[draw_index]++;
        end
        if (draw_stone_flag) flag_cycles++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (draw_stone_flag) done_with_flag++;
        end
    end

    logic [19:0] exp_px [$];
    int          exp_flag;

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    function automatic logic [31:0] mk(int xx, int yy, int t, int v, int m);
        logic [3:0] j1;
        logic [6:0] j2;
        j1 = 4'($urandom);
        j2 = 7'($urandom);
        return {9'(xx), j1, 8'(yy), j2, 2'(t), 1'(v), 1'(m)};
    endfunction

    // Expected plotted pixels and pass length, straight from the sprite rules.
    task automatic model(input int q);
        exp_px.delete();
        exp_flag = 2;
        for (int i = 0; i < q; i++) begin
            int bx, by, t;
            bx = int'(mem[i][31:23]);
            by = int'(mem[i][18:11]);
            t  = int'(mem[i][3:2]);
            exp_flag += 4;
            if (mem[i][1]) begin
                exp_flag += 256;
                for (int r = 0; r < 16; r++)
                    for (int c = 0; c < 16; c++) begin
                        logic [2:0] cl;
                        if (c == 0 || c == 15 || r == 0 || r == 15) cl = 3'b000;
                        else cl = (t == 0) ? 3'b111 : (t == 1) ? 3'b110 : (t == 2) ? 3'b011 : 3'b101;
                        if (bx + c < 320 && by + r < 240)
                            exp_px.push_back({9'(bx + c), 8'(by + r), cl});
                    end
            end
        end
    endtask

    int g0;
    int pidx0 [16];

    task automatic run_pass(input string name, input int q);
        int f0, d0, dw0, s, bad, first;
        model(q);
        g0 = got.size(); f0 = flag_cycles; d0 = done_cnt; dw0 = done_with_flag;
        pidx0 = plots_idx;
        quantity = 4'(q);
        step(); start = 1'b1; s = cyc;
        step(); start = 1'b0;
        for (int k = 0; k < 6000 && done_cnt == d0; k++) step();
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s timeout: no done within budget", name);
        end
        step(); step();
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++; $display("FAIL %s done_count: got %0d want 1", name, done_cnt - d0);
        end
        checks++;
        if (done_with_flag !== dw0) begin
            errors++; $display("FAIL %s flag_at_done: flag still high when done pulsed", name);
        end
        checks++;
        if (flag_cycles - f0 !== exp_flag) begin
            errors++; $display("FAIL %s flag_cycles: got %0d want %0d", name, flag_cycles - f0, exp_flag);
        end
        checks++;
        if (done_cyc - s !== exp_flag + 1) begin
            errors++; $display("FAIL %s done_latency: got %0d want %0d", name, done_cyc - s, exp_flag + 1);
        end
        checks++;
        if (got.size() - g0 !== exp_px.size()) begin
            errors++; $display("FAIL %s plot_count: got %0d want %0d", name, got.size() - g0, exp_px.size());
        end
        bad = 0; first = -1;
        for (int i = 0; i < exp_px.size() && g0 + i < got.size(); i++)
            if (got[g0 + i] !== exp_px[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s pixels: %0d wrong, first #%0d got x=%0d y=%0d c=%b want x=%0d y=%0d c=%b",
                     name, bad, first, got[g0+first][19:11], got[g0+first][10:3], got[g0+first][2:0],
                     exp_px[first][19:11], exp_px[first][10:3], exp_px[first][2:0]);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step(); step(); step();
        checks++;
        if ({draw_stone_flag, draw_index, x, y, colour, plot, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got flag=%b idx=%0d x=%0d y=%0d c=%b plot=%b done=%b want all 0",
                     draw_stone_flag, draw_index, x, y, colour, plot, done);
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_empty();
        run_pass("empty", 0);
    endtask

    task automatic test_single();
        mem[0] = mk(100, 50, 1, 1, 0);
        run_pass("single", 1);
        checks++;
        if (got[g0] !== {9'd100, 8'd50, 3'b000}) begin
            errors++; $display("FAIL single_first: got %h want %h", got[g0], {9'd100, 8'd50, 3'b000});
        end
        checks++;
        if (got[g0 + 17] !== {9'd101, 8'd51, 3'b110}) begin
            errors++; $display("FAIL single_interior: got %h want %h", got[g0 + 17], {9'd101, 8'd51, 3'b110});
        end
        checks++;
        if (got[g0 + 255] !== {9'd115, 8'd65, 3'b000}) begin
            errors++; $display("FAIL single_last: got %h want %h", got[g0 + 255], {9'd115, 8'd65, 3'b000});
        end
    endtask

    task automatic test_skip();
        mem[0] = mk(10, 20, 0, 1, 0);
        mem[1] = mk(40, 60, 2, 0, 1);
        mem[2] = mk(200, 100, 3, 1, 0);
        run_pass("skip", 3);
        checks++;
        if (plots_idx[1] - pidx0[1] !== 0) begin
            errors++; $display("FAIL skip_idx1_plots: got %0d want 0", plots_idx[1] - pidx0[1]);
        end
        checks++;
        if (plots_idx[0] - pidx0[0] !== 256 || plots_idx[2] - pidx0[2] !== 256) begin
            errors++; $display("FAIL skip_idx_plots: got %0d/%0d want 256/256",
                               plots_idx[0] - pidx0[0], plots_idx[2] - pidx0[2]);
        end
    endtask

    task automatic test_clip();
        mem[0] = mk(310, 230, 2, 1, 0);
        run_pass("clip", 1);
    endtask

    task automatic test_types();
        mem[0] = mk(0, 0, 0, 1, 1);
        mem[1] = mk(50, 150, 3, 1, 1);
        run_pass("types", 2);
        checks++;
        if (got[g0 + 17][2:0] !== 3'b111 || got[g0 + 256 + 17][2:0] !== 3'b101) begin
            errors++; $display("FAIL types_interior: got %b/%b want 111/101",
                               got[g0 + 17][2:0], got[g0 + 256 + 17][2:0]);
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 4; p++) begin
            int q;
            q = (p == 0) ? 15 : int'($urandom_range(1, 15));
            for (int i = 0; i < 16; i++)
                mem[i] = mk(int'($urandom_range(0, 511)), int'($urandom_range(0, 255)),
                            int'($urandom_range(0, 3)), int'($urandom_range(0, 3) != 0),
                            int'($urandom_range(0, 1)));
            run_pass($sformatf("random%0d", p), q);
        end
    endtask

    task automatic test_reset_mid();
        int d0, gs;
        mem[0] = mk(60, 70, 1, 1, 0);
        mem[1] = mk(80, 90, 2, 1, 0);
        model(2);
        g0 = got.size(); d0 = done_cnt;
        quantity = 4'd2;
        step(); start = 1'b1;
        step(); start = 1'b0;
        for (int k = 0; k < 100 && got.size() - g0 < 20; k++) step();
        start = 1'b1;
        step(); start = 1'b0;
        for (int k = 0; k < 100 && got.size() - g0 < 40; k++) step();
        resetn = 1'b0;
        step();
        checks++;
        if (draw_stone_flag !== 1'b0 || plot !== 1'b0 || draw_index !== 4'd0) begin
            errors++; $display("FAIL midreset_outputs: got flag=%b plot=%b idx=%0d want 0/0/0",
                               draw_stone_flag, plot, draw_index);
        end
        resetn = 1'b1;
        checks++;
        if (got.size() - g0 < 40 || got[g0 + 39] !== exp_px[39]) begin
            errors++; $display("FAIL midreset_prefix: plots=%0d pixel39 wrong (want %h)",
                               got.size() - g0, exp_px[39]);
        end
        gs = got.size();
        for (int k = 0; k < 20; k++) step();
        checks++;
        if (done_cnt !== d0 || got.size() !== gs) begin
            errors++; $display("FAIL midreset_quiet: done=%0d plots=%0d want 0/0", done_cnt - d0, got.size() - gs);
        end
        run_pass("after_reset", 2);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = '0;
            plots_idx[i] = 0;
        end
        test_reset();
        test_empty();
        test_single();
        test_skip();
        test_clip();
        test_types();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
